// File: rtl/hack_mem_pkg.sv
// Hack memory map constants and region decode helpers.
// Shared by the memory/IO subsystem and its keyboard FIFO.
package hack_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int RAM_AW = 14;
    localparam int SCR_AW = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE      = 15'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE      = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR      = 15'h6000;
    localparam logic [ADDR_W-1:0] KBD_STAT_ADDR = 15'h6001;
    localparam logic [ADDR_W-1:0] LED_ADDR      = 15'h6002;
    localparam logic [ADDR_W-1:0] TIMER_ADDR    = 15'h6003;

    // RAM occupies the lower half: bit 14 clear.
    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return a[14] == RAM_BASE[14];
    endfunction

    // Screen occupies 0x4000-0x5FFF: top two bits 2'b10.
    function automatic logic is_scr(input logic [ADDR_W-1:0] a);
        return a[14:13] == SCR_BASE[14:13];
    endfunction

endpackage

// File: rtl/hack_mem_map_kbd_fifo.sv
// Keyboard scan-code FIFO: push from the keyboard, pop by CPU access.
// Ports: clk_i, rst_i, push_i/data_i, pop_i, head_o, count_o, ready_o.
module kbd_fifo
    import hack_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              ready_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    // Full refuses a push even when a pop happens in the same cycle;
    // empty ignores a pop even when a push happens in the same cycle.
    assign ready_o = (count_q != CW'(DEPTH));
    assign do_push = push_i && ready_o;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign head_o  = (count_q == '0) ? '0 : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/hack_mem_map.sv
// Hack memory/IO subsystem: RAM, screen port, keyboard FIFO, LED, timer.
// Ports: CPU side (addressM/outM/writeM/inM), screen, keyboard, led.
module hack_mem_map
    import hack_mem_pkg::*;
#(
    parameter int KBD_DEPTH = 4,
    parameter int TICK_DIV  = 16000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] addressM,
    input  logic [DATA_W-1:0] outM,
    input  logic              writeM,
    output logic [DATA_W-1:0] inM,
    output logic [SCR_AW-1:0] scr_addr,
    output logic [DATA_W-1:0] scr_wdata,
    output logic              scr_we,
    input  logic [DATA_W-1:0] scr_rdata,
    input  logic [DATA_W-1:0] kbd_code,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic [DATA_W-1:0] led
);

    localparam int CW = $clog2(KBD_DEPTH + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DATA_W-1:0] ram_q [2**RAM_AW];
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] timer_q, timer_d;
    logic [TW-1:0]     presc_q, presc_d;

    logic              sel_ram;
    logic              sel_scr;
    logic              sel_kbd;
    logic              sel_stat;
    logic              sel_led;
    logic              sel_tmr;
    logic              tick;
    logic [DATA_W-1:0] kbd_head;
    logic [CW-1:0]     kbd_count;

    assign sel_ram  = is_ram(addressM);
    assign sel_scr  = is_scr(addressM);
    assign sel_kbd  = (addressM == KBD_ADDR);
    assign sel_stat = (addressM == KBD_STAT_ADDR);
    assign sel_led  = (addressM == LED_ADDR);
    assign sel_tmr  = (addressM == TIMER_ADDR);

    // RAM and screen writes are not gated by reset.
    always_ff @(posedge CLK) begin
        if (writeM && sel_ram) begin
            ram_q[addressM[RAM_AW-1:0]] <= outM;
        end
    end

    assign scr_addr  = addressM[SCR_AW-1:0];
    assign scr_wdata = outM;
    assign scr_we    = writeM && sel_scr;

    kbd_fifo #(
        .DEPTH(KBD_DEPTH)
    ) u_kbd_fifo (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (kbd_valid),
        .data_i (kbd_code),
        .pop_i  (writeM && sel_kbd),
        .head_o (kbd_head),
        .count_o(kbd_count),
        .ready_o(kbd_ready)
    );

    assign tick = (presc_q == TW'(TICK_DIV - 1));

    // A CPU write to TIMER overrides a coincident tick.
    always_comb begin
        led_d   = led_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        timer_d = timer_q + DATA_W'(tick);
        if (writeM && sel_led) begin
            led_d = outM;
        end
        if (writeM && sel_tmr) begin
            timer_d = outM;
            presc_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q   <= '0;
            timer_q <= '0;
            presc_q <= '0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
        end
    end

    assign led = led_q;

    always_comb begin
        inM = '0;
        unique case (1'b1)
            sel_ram:  inM = ram_q[addressM[RAM_AW-1:0]];
            sel_scr:  inM = scr_rdata;
            sel_kbd:  inM = kbd_head;
            sel_stat: inM = {{(DATA_W - CW){1'b0}}, kbd_count};
            sel_led:  inM = led_q;
            sel_tmr:  inM = timer_q;
            default:  inM = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_mem_map.sv
// Scoreboard bench for hack_mem_map against a queue/array reference model.
// Ports: none; drives all DUT ports, checks inM/screen/kbd_ready/led.
module tb_hack_mem_map;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [12:0] scr_addr;
    logic [15:0] scr_wdata;
    logic        scr_we;
    logic [15:0] scr_rdata;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [15:0] led;

    hack_mem_map #(
        .KBD_DEPTH(DEPTH),
        .TICK_DIV (TICK)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .addressM (addressM),
        .outM     (outM),
        .writeM   (writeM),
        .inM      (inM),
        .scr_addr (scr_addr),
        .scr_wdata(scr_wdata),
        .scr_we   (scr_we),
        .scr_rdata(scr_rdata),
        .kbd_code (kbd_code),
        .kbd_valid(kbd_valid),
        .kbd_ready(kbd_ready),
        .led      (led)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   armed   = 1'b0;

    // Reference model state
    logic [15:0] ram_m [int];
    logic [15:0] kq[$];
    logic [15:0] led_m;
    int unsigned load_m;
    int unsigned cyc_m;

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            0:       return inM;
            1:       return {15'b0, kbd_ready};
            2:       return {15'b0, scr_we};
            3:       return {3'b0, scr_addr};
            4:       return scr_wdata;
            default: return led;
        endcase
    endfunction

    // Monitor: everything queued for this cycle is compared mid-cycle.
    always @(negedge CLK) begin
        chk_t        c;
        logic [15:0] act;
        while (sbq.size() > 0) begin
            c   = sbq.pop_front();
            act = pick(c.sel);
            n_total++;
            if (act === c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t actual=%h required=%h",
                         c.name, $time, act, c.exp);
            end
        end
    end

    function automatic logic [15:0] timer_val();
        return 16'(load_m + cyc_m / TICK);
    endfunction

    task automatic expect_chk(input string n, input int s,
                              input logic [15:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        sbq.push_back(c);
    endtask

    task automatic cyc(input logic r, input logic [14:0] a,
                       input logic [15:0] d, input logic w,
                       input logic kv, input logic [15:0] kc,
                       input logic [15:0] sd);
        logic [15:0] e;
        bit          known;
        bit          do_pop;
        bit          do_push;
        RST       = r;
        addressM  = a;
        outM      = d;
        writeM    = w;
        kbd_valid = kv;
        kbd_code  = kc;
        scr_rdata = sd;
        if (armed) begin
            known = 1'b1;
            if (a < 15'h4000) begin
                known = ram_m.exists(int'(a));
                e = known ? ram_m[int'(a)] : 16'h0;
            end else if (a < 15'h6000) e = sd;
            else if (a == 15'h6000) e = (kq.size() > 0) ? kq[0] : 16'h0;
            else if (a == 15'h6001) e = 16'(kq.size());
            else if (a == 15'h6002) e = led_m;
            else if (a == 15'h6003) e = timer_val();
            else e = 16'h0;
            if (known) expect_chk("inM", 0, e);
            expect_chk("kbd_ready", 1, {15'b0, kq.size() != DEPTH});
            expect_chk("scr_we", 2,
                       {15'b0, w && a >= 15'h4000 && a < 15'h6000});
            expect_chk("scr_addr", 3, {3'b0, a[12:0]});
            expect_chk("scr_wdata", 4, d);
            expect_chk("led", 5, led_m);
        end
        @(posedge CLK);
        if (w && a < 15'h4000) ram_m[int'(a)] = d;
        if (r) begin
            led_m  = 16'h0;
            load_m = 0;
            cyc_m  = 0;
            kq.delete();
        end else begin
            if (w && a == 15'h6002) led_m = d;
            if (w && a == 15'h6003) begin
                load_m = int'(d);
                cyc_m  = 0;
            end else begin
                cyc_m++;
            end
            do_pop  = w && a == 15'h6000 && kq.size() > 0;
            do_push = kv && kq.size() < DEPTH;
            if (do_pop) void'(kq.pop_front());
            if (do_push) kq.push_back(kc);
        end
        #1;
    endtask

    task automatic rd(input logic [14:0] a);
        cyc(1'b0, a, 16'h0, 1'b0, 1'b0, 16'h0, 16'h1234);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        cyc(1'b0, a, d, 1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic push(input logic [15:0] k, input logic [14:0] a);
        cyc(1'b0, a, 16'h0, 1'b0, 1'b1, k, 16'h0);
    endtask

    initial begin
        logic [14:0] a;
        int          r;
        cyc(1'b1, 15'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        armed = 1'b1;
        cyc(1'b1, 15'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // RAM and LED after reset
        wr(15'h0010, 16'hBEEF);
        rd(15'h0010);
        rd(15'h6002);

        // Screen pass-through
        wr(15'h4123, 16'h00FF);
        cyc(1'b0, 15'h4123, 16'h0, 1'b0, 1'b0, 16'h0, 16'h5A5A);

        // Fill, overflow, pop
        push(16'h0041, 15'h6001);
        push(16'h0042, 15'h6001);
        push(16'h0043, 15'h6001);
        push(16'h0044, 15'h6001);
        push(16'h0099, 15'h6001);
        rd(15'h6000);
        wr(15'h6000, 16'h0);
        rd(15'h6001);
        rd(15'h6000);
        // Full + pop + push: pop happens, push refused
        push(16'h0050, 15'h6001);
        cyc(1'b0, 15'h6000, 16'h0, 1'b1, 1'b1, 16'h0051, 16'h0);
        rd(15'h6001);
        rd(15'h6000);
        wr(15'h6000, 16'h0);
        rd(15'h6001);
        // Count 2: simultaneous push + pop
        cyc(1'b0, 15'h6000, 16'h0, 1'b1, 1'b1, 16'h0045, 16'h0);
        rd(15'h6001);
        rd(15'h6000);
        wr(15'h6000, 16'h0);
        wr(15'h6000, 16'h0);
        rd(15'h6001);
        wr(15'h6000, 16'h0);
        // Empty: push + pop
        cyc(1'b0, 15'h6000, 16'h0, 1'b1, 1'b1, 16'h0046, 16'h0);
        rd(15'h6001);
        rd(15'h6000);

        // Timer from reset
        cyc(1'b1, 15'h6003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (13) rd(15'h6003);
        wr(15'h6003, 16'hFFFF);
        repeat (5) rd(15'h6003);
        wr(15'h6003, 16'hFFFF);
        repeat (3) rd(15'h6003);
        wr(15'h6003, 16'h0007);
        repeat (5) rd(15'h6003);

        // Reset clears registers, keeps RAM
        wr(15'h6002, 16'h00A5);
        push(16'h0061, 15'h6002);
        push(16'h0062, 15'h6001);
        rd(15'h6001);
        cyc(1'b1, 15'h6002, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        rd(15'h6002);
        rd(15'h6001);
        rd(15'h6003);
        rd(15'h0010);
        rd(15'h7000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) a = 15'($urandom_range(0, 31));
            else if (r == 3) a = 15'($urandom_range(16'h4000, 16'h5FFF));
            else if (r < 9) a = 15'($urandom_range(16'h6000, 16'h6003));
            else a = 15'($urandom_range(16'h6004, 16'h7FFF));
            cyc($urandom_range(0, 59) == 0, a, 16'($urandom),
                $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge CLK);
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain actual=%0d required=0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
